// File: rtl/program_decoder_pkg.sv
// Shared types and constants for the program block decoder.
// State encoding, header byte offsets and block type codes.
package program_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    H_LEN,
    H_AHI,
    H_ALO,
    H_TYPE,
    DATA
  } state_t;

  localparam int HDR_LEN   = 0;
  localparam int HDR_AHI   = 1;
  localparam int HDR_ALO   = 2;
  localparam int HDR_TYPE  = 3;
  localparam int HDR_BYTES = 4;

  localparam logic [7:0] BLK_TYPE_DATA = 8'h00;

endpackage

// File: rtl/program_block_decoder.sv
// Walks a byte-wide program ROM and decodes one block per accepted start.
// Ports: clk, rst (sync, active-high); prog_addr/prog_data to the ROM;
// start/ready/done handshake; block_length, block_address, block_type,
// block_data[] decoded fields. Macro PROGRAM_DECODER_DATA_CLEAR_EN zeroes
// block_data when a start is accepted.
module program_block_decoder
  import program_decoder_pkg::*;
#(
  parameter int PROGRAM_SIZE        = 64,
  parameter int DATA_BLOCK_MAX_SIZE = 128,
  localparam int PROG_ADDR_BITS     = $clog2(PROGRAM_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [7:0]                prog_data,
  input  logic                      start,
  output logic                      ready,
  output logic                      done,
  output logic [7:0]                block_length,
  output logic [15:0]               block_address,
  output logic [7:0]                block_type,
  output logic [7:0]                block_data [DATA_BLOCK_MAX_SIZE]
);

  localparam logic [PROG_ADDR_BITS-1:0] LAST_ADDR =
    PROG_ADDR_BITS'(PROGRAM_SIZE - 1);

  state_t state;
  logic [7:0] cnt;
  logic [PROG_ADDR_BITS-1:0] next_addr;

  // ROM pointer wraps at the end of the image
  always_comb begin
    next_addr = prog_addr + 1'b1;
    if (prog_addr == LAST_ADDR)
      next_addr = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      prog_addr     <= '0;
      ready         <= 1'b1;
      done          <= 1'b0;
      block_length  <= '0;
      block_address <= '0;
      block_type    <= '0;
      cnt           <= '0;
      for (int i = 0; i < DATA_BLOCK_MAX_SIZE; i++)
        block_data[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= H_LEN;
            ready <= 1'b0;
            done  <= 1'b0;
`ifdef PROGRAM_DECODER_DATA_CLEAR_EN
            for (int i = 0; i < DATA_BLOCK_MAX_SIZE; i++)
              block_data[i] <= '0;
`endif
          end
        end
        H_LEN: begin
          block_length <= prog_data;
          prog_addr    <= next_addr;
          state        <= H_AHI;
        end
        H_AHI: begin
          block_address[15:8] <= prog_data;
          prog_addr           <= next_addr;
          state               <= H_ALO;
        end
        H_ALO: begin
          block_address[7:0] <= prog_data;
          prog_addr          <= next_addr;
          state              <= H_TYPE;
        end
        H_TYPE: begin
          block_type <= prog_data;
          prog_addr  <= next_addr;
          cnt        <= '0;
          if (block_length == 8'd0) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          // bytes past the store depth still advance the pointer
          for (int i = 0; i < DATA_BLOCK_MAX_SIZE; i++)
            if (int'(cnt) == i)
              block_data[i] <= prog_data;
          prog_addr <= next_addr;
          cnt       <= cnt + 8'd1;
          if (cnt == block_length - 8'd1) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_block_decoder.sv
// Randomized self-checking bench for program_block_decoder.
// Drives a behavioural ROM and compares against a byte-level image model.
module tb_program_block_decoder;

  localparam int PS = 64;
  localparam int DM = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       ready;
  logic       done;
  logic [7:0] block_length;
  logic [15:0] block_address;
  logic [7:0] block_type;
  logic [7:0] block_data [DM];

  program_block_decoder #(
    .PROGRAM_SIZE(PS),
    .DATA_BLOCK_MAX_SIZE(DM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .start(start),
    .ready(ready),
    .done(done),
    .block_length(block_length),
    .block_address(block_address),
    .block_type(block_type),
    .block_data(block_data)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [PS];
  always @(negedge clk) prog_data <= rom[prog_addr];

  int n_chk = 0;
  int n_pass = 0;
  int ptr = 0;
  logic [7:0] exp_data [DM];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_data(input string tag);
    for (int i = 0; i < DM; i++)
      chk(tag, block_data[i], exp_data[i]);
  endtask

  task automatic run_block(input bit poke);
    int len, addr, typ, n;
    bit got;
    len  = rom[ptr];
    addr = {rom[(ptr + 1) % PS], rom[(ptr + 2) % PS]};
    typ  = rom[(ptr + 3) % PS];
`ifdef PROGRAM_DECODER_DATA_CLEAR_EN
    for (int i = 0; i < DM; i++) exp_data[i] = 8'h00;
`endif
    for (int i = 0; i < len && i < DM; i++)
      exp_data[i] = rom[(ptr + 4 + i) % PS];
    ptr = (ptr + 4 + len) % PS;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy", {done, ready}, 0);
    n = 0;
    got = 1'b0;
    while (n < 400 && !got) begin
      if (poke && n == 2) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
      got = done;
    end
    chk("done_seen", got, 1);
    chk("latency", n, len + 4);
    chk("ready", ready, 1);
    chk("length", block_length, len);
    chk("address", block_address, addr);
    chk("type", block_type, typ);
    chk("prog_addr", prog_addr, ptr);
    chk_data("data");
  endtask

  initial begin
    int len;
    start = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < PS; i++) rom[i] = $urandom_range(0, 255);
    for (int i = 0; i < DM; i++) exp_data[i] = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_len", block_length, 0);
    chk("rst_baddr", block_address, 0);
    chk("rst_type", block_type, 0);
    chk_data("rst_data");

    rom[0] = 8'h10; rom[1] = 8'h12; rom[2] = 8'h34; rom[3] = 8'h00;
    for (int i = 0; i < 16; i++) rom[4 + i] = 8'(8'h10 + i);
    rom[20] = 8'h10; rom[21] = 8'h56; rom[22] = 8'h78; rom[23] = 8'h00;
    for (int i = 0; i < 16; i++) rom[24 + i] = 8'(8'h20 + i);
    rom[40] = 8'h00; rom[41] = 8'hAB; rom[42] = 8'hCD; rom[43] = 8'h01;
    run_block(1'b0);
    chk("blk1_addr", block_address, 32'h1234);
    chk("blk1_d15", block_data[15], 32'h1F);
    run_block(1'b0);
    chk("blk2_addr", block_address, 32'h5678);
    run_block(1'b0);
    chk("blk3_addr", block_address, 32'hABCD);

    // a start pulse during decode must not disturb the block
    rom[44] = 8'd8;
    run_block(1'b1);

    // reset in the middle of a payload
    rom[ptr] = 8'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr = 0;
    for (int i = 0; i < DM; i++) exp_data[i] = 8'h00;
    chk("mrst_ready", ready, 1);
    chk("mrst_done", done, 0);
    chk("mrst_addr", prog_addr, 0);
    chk("mrst_len", block_length, 0);
    chk("mrst_baddr", block_address, 0);
    chk("mrst_type", block_type, 0);
    chk_data("mrst_data");

    // random images: long blocks, wrap across the ROM end
    for (int it = 0; it < 24; it++) begin
      if (it % 6 == 0)
        for (int i = 0; i < PS; i++) rom[i] = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) len = $urandom_range(129, 255);
      else len = $urandom_range(0, 40);
      rom[ptr] = 8'(len);
      run_block(it % 4 == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
